// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle instruction-fetch controller owning the SCCPU
// program counter. Sequences fetch (req/ack to instruction memory) and
// execute-wait, then commits the next PC from the core's NPC selection.
// Optional exception redirect is enabled by defining PC_SEQ_EXC_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000
`ifdef PC_SEQ_EXC_EN
    ,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
`endif
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    output logic [31:0] o_pc,
    input  logic        i_exec_done,
    input  logic [1:0]  i_npc_op,
    input  logic [25:0] i_imm,
    input  logic [31:0] i_pcjr,
    input  logic        i_halt,
    output logic        o_halted,
    output logic        o_err_misalign,
`ifdef PC_SEQ_EXC_EN
    input  logic        i_exc,
    output logic [31:0] o_epc,
`endif
    output logic [31:0] o_retired
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic [31:0] r_retired;
    logic        r_err_misalign;

    logic [31:0] w_p4;
    logic [31:0] w_npc;
    logic        w_commit;
    logic        w_latch;
    logic        w_jr_misalign;
    logic        w_fetch_exc;
    logic        w_exec_exc;

`ifdef PC_SEQ_EXC_EN
    logic [31:0] r_epc;
    logic        r_exc_pend;

    // A fetch that saw an exception (earlier or on the ack cycle) is discarded
    assign w_fetch_exc = (r_state == S_FETCH) && i_imem_ack && (r_exc_pend || i_exc);
    assign w_exec_exc  = (r_state == S_EXEC) && i_exc;
    assign o_epc       = r_epc;
`else
    assign w_fetch_exc = 1'b0;
    assign w_exec_exc  = 1'b0;
`endif

    assign w_latch       = (r_state == S_FETCH) && i_imem_ack && !w_fetch_exc;
    assign w_commit      = (r_state == S_EXEC) && i_exec_done && !w_exec_exc;
    assign w_p4          = r_pc + 32'd4;
    assign w_jr_misalign = (i_npc_op == NPC_JR) && (i_pcjr[1:0] != 2'b00);

    assign o_imem_req     = (r_state == S_FETCH);
    assign o_imem_addr    = r_pc;
    assign o_instr        = r_instr;
    assign o_instr_valid  = r_instr_valid;
    assign o_pc           = r_pc;
    assign o_halted       = (r_state == S_HALT);
    assign o_err_misalign = r_err_misalign;
    assign o_retired      = r_retired;

    // Next-PC selection from the execute stage's npc_op
    always_comb begin
        w_npc = w_p4;
        case (i_npc_op)
            NPC_PLUS4:  w_npc = w_p4;
            NPC_BRANCH: w_npc = w_p4 + {{14{i_imm[15]}}, i_imm[15:0], 2'b00};
            NPC_JUMP:   w_npc = {w_p4[31:28], i_imm, 2'b00};
            NPC_JR:     w_npc = {i_pcjr[31:2], 2'b00};
            default:    w_npc = w_p4;
        endcase
    end

    // Next-state logic; an exception during fetch keeps us fetching at the vector
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = S_FETCH;
            S_FETCH: begin
                if (i_imem_ack) begin
                    w_next_state = w_fetch_exc ? S_FETCH : S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_exec_exc) begin
                    w_next_state = S_FETCH;
                end else if (i_exec_done) begin
                    w_next_state = i_halt ? S_HALT : S_FETCH;
                end
            end
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Instruction latch, PC commit, retire counter and sticky misalign flag
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_pc           <= RESET_PC;
            r_instr        <= 32'd0;
            r_instr_valid  <= 1'b0;
            r_retired      <= 32'd0;
            r_err_misalign <= 1'b0;
        end else begin
            r_instr_valid <= w_latch;
            if (w_latch) begin
                r_instr <= i_imem_rdata;
            end
            if (w_commit) begin
                r_pc      <= w_npc;
                r_retired <= r_retired + 32'd1;
                if (w_jr_misalign) begin
                    r_err_misalign <= 1'b1;
                end
            end
`ifdef PC_SEQ_EXC_EN
            if (w_fetch_exc || w_exec_exc) begin
                r_pc <= EXC_VECTOR;
            end
`endif
        end
    end

`ifdef PC_SEQ_EXC_EN
    // Exception bookkeeping: EPC capture and the pending flag held across a fetch
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_epc      <= 32'd0;
            r_exc_pend <= 1'b0;
        end else begin
            if (w_fetch_exc || w_exec_exc) begin
                r_epc <= r_pc;
            end
            if (r_state == S_FETCH) begin
                if (i_imem_ack) begin
                    r_exc_pend <= 1'b0;
                end else if (i_exc) begin
                    r_exc_pend <= 1'b1;
                end
            end else begin
                r_exc_pend <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
// Exception scenarios are compiled in only when PC_SEQ_EXC_EN is defined.
module tb_pc_sequencer;

    logic        clk;
    logic        rstn;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic [31:0] instr;
    logic        instrValid;
    logic [31:0] pc;
    logic        execDone;
    logic [1:0]  npcOp;
    logic [25:0] imm;
    logic [31:0] pcjr;
    logic        halt;
    logic        halted;
    logic        errMisalign;
    logic [31:0] retired;
`ifdef PC_SEQ_EXC_EN
    logic        exc;
    logic [31:0] epc;
`endif

    int checkCount = 0;
    int failCount  = 0;

    pc_sequencer dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .o_imem_req     (imemReq),
        .o_imem_addr    (imemAddr),
        .i_imem_ack     (imemAck),
        .i_imem_rdata   (imemRdata),
        .o_instr        (instr),
        .o_instr_valid  (instrValid),
        .o_pc           (pc),
        .i_exec_done    (execDone),
        .i_npc_op       (npcOp),
        .i_imm          (imm),
        .i_pcjr         (pcjr),
        .i_halt         (halt),
        .o_halted       (halted),
        .o_err_misalign (errMisalign),
`ifdef PC_SEQ_EXC_EN
        .i_exc          (exc),
        .o_epc          (epc),
`endif
        .o_retired      (retired)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the rising edge
    task cycle();
        @(posedge clk);
        #1;
    endtask

    // Run one complete instruction starting in S_FETCH: immediate ack, then exec_done
    task applyStimulus(input logic [1:0] op, input logic [25:0] immVal,
                       input logic [31:0] jrVal, input logic haltVal);
        imemAck   = 1'b1;
        imemRdata = 32'h2400_0000 | {6'd0, immVal};
        cycle();
        imemAck   = 1'b0;
        execDone  = 1'b1;
        npcOp     = op;
        imm       = immVal;
        pcjr      = jrVal;
        halt      = haltVal;
        cycle();
        execDone  = 1'b0;
        halt      = 1'b0;
        npcOp     = 2'b00;
    endtask

    task test_reset();
        rstn      = 1'b0;
        imemAck   = 1'b0;
        imemRdata = 32'd0;
        execDone  = 1'b0;
        npcOp     = 2'b00;
        imm       = 26'd0;
        pcjr      = 32'd0;
        halt      = 1'b0;
`ifdef PC_SEQ_EXC_EN
        exc       = 1'b0;
`endif
        cycle();
        cycle();
        checkCount++; if (pc !== 32'h0000_3000) begin failCount++; $display("[TB] FAIL reset_pc got %h want %h", pc, 32'h0000_3000); end
        checkCount++; if (instr !== 32'd0) begin failCount++; $display("[TB] FAIL reset_instr got %h want %h", instr, 32'd0); end
        checkCount++; if (retired !== 32'd0) begin failCount++; $display("[TB] FAIL reset_retired got %h want %h", retired, 32'd0); end
        checkCount++; if (instrValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid got %b want 0", instrValid); end
        checkCount++; if (imemReq !== 1'b0) begin failCount++; $display("[TB] FAIL reset_req got %b want 0", imemReq); end
        checkCount++; if (halted !== 1'b0) begin failCount++; $display("[TB] FAIL reset_halted got %b want 0", halted); end
        checkCount++; if (errMisalign !== 1'b0) begin failCount++; $display("[TB] FAIL reset_err got %b want 0", errMisalign); end
`ifdef PC_SEQ_EXC_EN
        checkCount++; if (epc !== 32'd0) begin failCount++; $display("[TB] FAIL reset_epc got %h want %h", epc, 32'd0); end
`endif
        rstn = 1'b1;
        checkCount++; if (imemReq !== 1'b0) begin failCount++; $display("[TB] FAIL idle_req got %b want 0", imemReq); end
        cycle();
        checkCount++; if (imemReq !== 1'b1) begin failCount++; $display("[TB] FAIL first_req got %b want 1", imemReq); end
        checkCount++; if (imemAddr !== 32'h0000_3000) begin failCount++; $display("[TB] FAIL first_addr got %h want %h", imemAddr, 32'h0000_3000); end
    endtask

    task test_fetch_plus4();
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkCount++; if (imemReq !== 1'b1 || imemAddr !== 32'h0000_3000) begin failCount++; $display("[TB] FAIL hold_req got req=%b addr=%h want req=1 addr=%h", imemReq, imemAddr, 32'h0000_3000); end
            checkCount++; if (instrValid !== 1'b0) begin failCount++; $display("[TB] FAIL hold_valid got %b want 0", instrValid); end
        end
        imemAck   = 1'b1;
        imemRdata = 32'hDEAD_BEEF;
        cycle();
        imemAck   = 1'b0;
        checkCount++; if (instrValid !== 1'b1) begin failCount++; $display("[TB] FAIL ack_valid got %b want 1", instrValid); end
        checkCount++; if (instr !== 32'hDEAD_BEEF) begin failCount++; $display("[TB] FAIL ack_instr got %h want %h", instr, 32'hDEAD_BEEF); end
        checkCount++; if (imemReq !== 1'b0) begin failCount++; $display("[TB] FAIL ack_req_drop got %b want 0", imemReq); end
        execDone = 1'b1;
        npcOp    = 2'b00;
        cycle();
        execDone = 1'b0;
        checkCount++; if (instrValid !== 1'b0) begin failCount++; $display("[TB] FAIL valid_pulse got %b want 0", instrValid); end
        checkCount++; if (pc !== 32'h0000_3004) begin failCount++; $display("[TB] FAIL plus4_pc got %h want %h", pc, 32'h0000_3004); end
        checkCount++; if (imemReq !== 1'b1 || imemAddr !== 32'h0000_3004) begin failCount++; $display("[TB] FAIL plus4_refetch got req=%b addr=%h want req=1 addr=%h", imemReq, imemAddr, 32'h0000_3004); end
        checkCount++; if (retired !== 32'd1) begin failCount++; $display("[TB] FAIL plus4_retired got %0d want 1", retired); end
    endtask

    task test_npc();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b00, 26'd0, 32'd0, 1'b0);
        end
        checkCount++; if (pc !== 32'h0000_3010) begin failCount++; $display("[TB] FAIL seq_pc got %h want %h", pc, 32'h0000_3010); end
        applyStimulus(2'b01, 26'h000_FFFC, 32'd0, 1'b0);
        checkCount++; if (pc !== 32'h0000_3004) begin failCount++; $display("[TB] FAIL branch_pc got %h want %h", pc, 32'h0000_3004); end
        applyStimulus(2'b10, 26'h000_0C04, 32'd0, 1'b0);
        checkCount++; if (pc !== 32'h0000_3010) begin failCount++; $display("[TB] FAIL jump_pc got %h want %h", pc, 32'h0000_3010); end
        applyStimulus(2'b11, 26'd0, 32'h0000_3023, 1'b0);
        checkCount++; if (pc !== 32'h0000_3020) begin failCount++; $display("[TB] FAIL jr_pc got %h want %h", pc, 32'h0000_3020); end
        checkCount++; if (errMisalign !== 1'b1) begin failCount++; $display("[TB] FAIL jr_err got %b want 1", errMisalign); end
        applyStimulus(2'b00, 26'd0, 32'd0, 1'b0);
        checkCount++; if (errMisalign !== 1'b1) begin failCount++; $display("[TB] FAIL err_sticky got %b want 1", errMisalign); end
        checkCount++; if (pc !== 32'h0000_3024) begin failCount++; $display("[TB] FAIL after_jr_pc got %h want %h", pc, 32'h0000_3024); end
        checkCount++; if (retired !== 32'd8) begin failCount++; $display("[TB] FAIL npc_retired got %0d want 8", retired); end
    endtask

    task test_halt();
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
        cycle();
        applyStimulus(2'b00, 26'd0, 32'd0, 1'b1);
        checkCount++; if (halted !== 1'b1) begin failCount++; $display("[TB] FAIL halt_flag got %b want 1", halted); end
        checkCount++; if (pc !== 32'h0000_3004) begin failCount++; $display("[TB] FAIL halt_pc got %h want %h", pc, 32'h0000_3004); end
        checkCount++; if (retired !== 32'd1) begin failCount++; $display("[TB] FAIL halt_retired got %0d want 1", retired); end
        imemAck  = 1'b1;
        execDone = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            checkCount++; if (imemReq !== 1'b0 || halted !== 1'b1) begin failCount++; $display("[TB] FAIL halt_hold got req=%b halted=%b want req=0 halted=1", imemReq, halted); end
        end
        imemAck  = 1'b0;
        execDone = 1'b0;
        checkCount++; if (pc !== 32'h0000_3004 || retired !== 32'd1) begin failCount++; $display("[TB] FAIL halt_frozen got pc=%h retired=%0d want pc=%h retired=1", pc, retired, 32'h0000_3004); end
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
        checkCount++; if (pc !== 32'h0000_3000 || halted !== 1'b0) begin failCount++; $display("[TB] FAIL halt_reset got pc=%h halted=%b want pc=%h halted=0", pc, halted, 32'h0000_3000); end
        checkCount++; if (errMisalign !== 1'b0 || retired !== 32'd0) begin failCount++; $display("[TB] FAIL halt_reset_clear got err=%b retired=%0d want err=0 retired=0", errMisalign, retired); end
        cycle();
        checkCount++; if (imemReq !== 1'b1 || imemAddr !== 32'h0000_3000) begin failCount++; $display("[TB] FAIL resume_fetch got req=%b addr=%h want req=1 addr=%h", imemReq, imemAddr, 32'h0000_3000); end
    endtask

    task test_retired_wrap();
        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        applyStimulus(2'b00, 26'd0, 32'd0, 1'b0);
        checkCount++; if (retired !== 32'd0) begin failCount++; $display("[TB] FAIL retired_wrap got %h want %h", retired, 32'd0); end
        checkCount++; if (pc !== 32'h0000_3004) begin failCount++; $display("[TB] FAIL wrap_pc got %h want %h", pc, 32'h0000_3004); end
    endtask

`ifdef PC_SEQ_EXC_EN
    task test_exc_fetch();
        applyStimulus(2'b00, 26'd0, 32'd0, 1'b0);
        checkCount++; if (imemAddr !== 32'h0000_3008) begin failCount++; $display("[TB] FAIL excf_start got %h want %h", imemAddr, 32'h0000_3008); end
        exc = 1'b1;
        cycle();
        exc = 1'b0;
        cycle();
        checkCount++; if (imemReq !== 1'b1 || imemAddr !== 32'h0000_3008) begin failCount++; $display("[TB] FAIL excf_hold got req=%b addr=%h want req=1 addr=%h", imemReq, imemAddr, 32'h0000_3008); end
        imemAck   = 1'b1;
        imemRdata = 32'h1234_5678;
        cycle();
        imemAck   = 1'b0;
        checkCount++; if (instrValid !== 1'b0) begin failCount++; $display("[TB] FAIL excf_valid got %b want 0", instrValid); end
        checkCount++; if (epc !== 32'h0000_3008) begin failCount++; $display("[TB] FAIL excf_epc got %h want %h", epc, 32'h0000_3008); end
        checkCount++; if (imemReq !== 1'b1 || imemAddr !== 32'h0000_4180) begin failCount++; $display("[TB] FAIL excf_vector got req=%b addr=%h want req=1 addr=%h", imemReq, imemAddr, 32'h0000_4180); end
    endtask

    task test_exc_exec();
        imemAck = 1'b1;
        cycle();
        imemAck  = 1'b0;
        execDone = 1'b1;
        exc      = 1'b1;
        halt     = 1'b1;
        cycle();
        execDone = 1'b0;
        exc      = 1'b0;
        halt     = 1'b0;
        checkCount++; if (epc !== 32'h0000_4180) begin failCount++; $display("[TB] FAIL exce_epc got %h want %h", epc, 32'h0000_4180); end
        checkCount++; if (retired !== 32'd1) begin failCount++; $display("[TB] FAIL exce_retired got %0d want 1", retired); end
        checkCount++; if (halted !== 1'b0 || imemReq !== 1'b1 || pc !== 32'h0000_4180) begin failCount++; $display("[TB] FAIL exce_redirect got halted=%b req=%b pc=%h want halted=0 req=1 pc=%h", halted, imemReq, pc, 32'h0000_4180); end
    endtask
`endif

    // Scenario sequence followed by the single summary line
    initial begin
        $display("[TB] starting pc_sequencer directed tests");
        test_reset();
        test_fetch_plus4();
        test_npc();
        test_halt();
        test_retired_wrap();
`ifdef PC_SEQ_EXC_EN
        test_exc_fetch();
        test_exc_exec();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
